systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl.sv | 169 ++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// Operand feed sequencer for an ARRAY_DIM x ARRAY_DIM systolic array: clear, read k_len beats, skew lanes, drain.
// Optional abort input enabled by defining FEED_CTRL_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for start with nonzero k_len
// CLEAR   | one cycle of pe_clear to zero PE accumulators
// FEED    | k_len cycles of operand-buffer reads
// DRAIN   | 3*ARRAY_DIM cycles for data to flush through the array
// DONE    | one-cycle done pulse
module systolic_feed_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_DIM  = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              k_len,
`ifdef FEED_CTRL_ABORT_EN
    input  logic                            abort,
`endif
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [K_WIDTH-1:0]              rd_addr,
    input  logic [DATA_WIDTH*ARRAY_DIM-1:0] a_in,
    input  logic [DATA_WIDTH*ARRAY_DIM-1:0] b_in,
    output logic [DATA_WIDTH*ARRAY_DIM-1:0] left_out,
    output logic [DATA_WIDTH*ARRAY_DIM-1:0] top_out,
    output logic                            pe_clear
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int DRAIN_CYC = 3 * ARRAY_DIM;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    logic [2:0]            state_q, state_d;
    logic [K_WIDTH-1:0]    k_len_q, k_len_d;
    logic [K_WIDTH-1:0]    addr_q, addr_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  clr_pulse_q, clr_pulse_d;
    logic                  lane_vld_q, lane_vld_d;
    logic [DATA_WIDTH-1:0] left_sr_q [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_WIDTH-1:0] left_sr_d [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_WIDTH-1:0] top_sr_q  [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_WIDTH-1:0] top_sr_d  [ARRAY_DIM][ARRAY_DIM];
    logic                  abort_hit;

`ifdef FEED_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign rd_en    = (state_q == S_FEED);
    assign rd_addr  = addr_q;
    assign pe_clear = (state_q == S_CLEAR) || clr_pulse_q;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        clr_pulse_d = abort_hit;
        case (state_q)
            S_IDLE: begin
                if (start && k_len != '0) begin
                    k_len_d = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (addr_q == k_len_q - K_WIDTH'(1)) begin
                    addr_d  = '0;
                    drain_d = DRAIN_LAST;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + K_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            addr_d  = '0;
            drain_d = '0;
        end
    end

    // Each lane shifts through a full-length chain; row/column i taps stage i for i+1 delays.
    always_comb begin
        lane_vld_d = rd_en && !abort_hit;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            for (int s = 0; s < ARRAY_DIM; s++) begin
                left_sr_d[i][s] = '0;
                top_sr_d[i][s]  = '0;
                if (!abort_hit) begin
                    if (s == 0) begin
                        left_sr_d[i][s] = lane_vld_q ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                        top_sr_d[i][s]  = lane_vld_q ? b_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    end else begin
                        left_sr_d[i][s] = left_sr_q[i][s-1];
                        top_sr_d[i][s]  = top_sr_q[i][s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        left_out = '0;
        top_out  = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            left_out[i*DATA_WIDTH +: DATA_WIDTH] = left_sr_q[i][i];
            top_out[i*DATA_WIDTH +: DATA_WIDTH]  = top_sr_q[i][i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
            clr_pulse_q <= 1'b0;
            lane_vld_q  <= 1'b0;
            for (int i = 0; i < ARRAY_DIM; i++) begin
                for (int s = 0; s < ARRAY_DIM; s++) begin
                    left_sr_q[i][s] <= '0;
                    top_sr_q[i][s]  <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            clr_pulse_q <= clr_pulse_d;
            lane_vld_q  <= lane_vld_d;
            for (int i = 0; i < ARRAY_DIM; i++) begin
                for (int s = 0; s < ARRAY_DIM; s++) begin
                    left_sr_q[i][s] <= left_sr_d[i][s];
                    top_sr_q[i][s]  <= top_sr_d[i][s];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench for systolic_feed_ctrl against a tile-level timing model.
// Exercises abort when compiled with FEED_CTRL_ABORT_EN.
module tb_systolic_feed_ctrl;
    localparam int DW   = 16;
    localparam int N    = 4;
    localparam int KW   = 8;
    localparam int LW   = DW * N;
    localparam int MAXC = 2200;
`ifdef FEED_CTRL_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [LW-1:0] a_in = '0;
    logic [LW-1:0] b_in = '0;
    logic          busy, done, rd_en, pe_clear;
    logic [KW-1:0] rd_addr;
    logic [LW-1:0] left_out, top_out;

    systolic_feed_ctrl #(.DATA_WIDTH(DW), .ARRAY_DIM(N), .K_WIDTH(KW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .k_len    (k_len),
`ifdef FEED_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .a_in     (a_in),
        .b_in     (b_in),
        .left_out (left_out),
        .top_out  (top_out),
        .pe_clear (pe_clear)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int t0 = 0;
    int kk = 0;
    bit active = 1'b0;
    int abort_clr = -1;
    int done_seen = 0;
    logic [LW-1:0] a_hist [MAXC];
    logic [LW-1:0] b_hist [MAXC];
    bit            rd_hist [MAXC];

    task automatic chk_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs from the tile schedule, compare, advance model.
    task automatic run_cycle(input logic st, input int k, input logic rp, input logic ab, input logic pat);
        int e, r;
        bit busy_e, done_e, clr_e, rd_e;
        logic [KW-1:0] addr_e;
        logic [LW-1:0] el, et;
        @(posedge clk);
        #1;
        start = st;
        k_len = KW'(k);
        abort = ABORT_ON ? ab : 1'b0;
        for (int i = 0; i < N; i++) begin
            a_in[i*DW +: DW] = pat ? DW'(16'h0010 + i) : DW'($urandom);
            b_in[i*DW +: DW] = pat ? DW'(16'h0100 + i) : DW'($urandom);
        end
        a_hist[cyc] = a_in;
        b_hist[cyc] = b_in;
        if (rp) begin
            reset = 1'b1;
            active = 1'b0;
            abort_clr = -1;
            for (int x = 0; x < cyc; x++) rd_hist[x] = 1'b0;
        end
        e      = cyc - t0;
        busy_e = active && e >= 1 && e <= kk + 1 + 3 * N;
        done_e = active && e == kk + 2 + 3 * N;
        rd_e   = active && e >= 2 && e <= kk + 1;
        clr_e  = (active && e == 1) || (cyc == abort_clr);
        addr_e = rd_e ? KW'(e - 2) : '0;
        busy_e = busy_e || done_e;
        rd_hist[cyc] = rd_e;
        el = '0;
        et = '0;
        for (int i = 0; i < N; i++) begin
            r = cyc - i - 2;
            if (r >= 0 && rd_hist[r]) begin
                el[i*DW +: DW] = a_hist[r+1][i*DW +: DW];
                et[i*DW +: DW] = b_hist[r+1][i*DW +: DW];
            end
        end
        @(negedge clk);
        chk_eq("busy", LW'(busy), LW'(busy_e));
        chk_eq("done", LW'(done), LW'(done_e));
        chk_eq("rd_en", LW'(rd_en), LW'(rd_e));
        chk_eq("rd_addr", LW'(rd_addr), LW'(addr_e));
        chk_eq("pe_clear", LW'(pe_clear), LW'(clr_e));
        chk_eq("left_out", left_out, el);
        chk_eq("top_out", top_out, et);
        if (done === 1'b1) done_seen++;
        if (rp) begin
            #1 reset = 1'b0;
        end else begin
            if (done_e) active = 1'b0;
            if (ab && ABORT_ON && busy_e && !done_e) begin
                active = 1'b0;
                abort_clr = cyc + 1;
                for (int x = 0; x <= cyc; x++) rd_hist[x] = 1'b0;
            end
            if (st && !busy_e && k != 0) begin
                active = 1'b1;
                t0 = cyc;
                kk = k;
            end
        end
        cyc++;
    endtask

    initial begin
        int k;
        bit st, rp, ab;
        #3;
        chk_eq("rst_busy", LW'(busy), '0);
        chk_eq("rst_done", LW'(done), '0);
        chk_eq("rst_rd_en", LW'(rd_en), '0);
        chk_eq("rst_rd_addr", LW'(rd_addr), '0);
        chk_eq("rst_pe_clear", LW'(pe_clear), '0);
        chk_eq("rst_left", left_out, '0);
        chk_eq("rst_top", top_out, '0);
        #9 reset = 1'b0;

        // nominal tile with an ignored second start at cycle 5
        done_seen = 0;
        run_cycle(1'b1, 4, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 25; c++) run_cycle(c == 5, 7, 1'b0, 1'b0, 1'b1);
        chk_eq("done_count", LW'(done_seen), LW'(1));

        // zero-length start is ignored
        run_cycle(1'b1, 0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // reset during a k_len=8 tile, then a fresh tile
        done_seen = 0;
        run_cycle(1'b1, 8, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 6; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk_eq("done_after_rst", LW'(done_seen), '0);
        run_cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 24; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);

`ifdef FEED_CTRL_ABORT_EN
        done_seen = 0;
        run_cycle(1'b1, 4, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 4; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) run_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk_eq("done_after_abort", LW'(done_seen), '0);
`endif

        for (int c = 0; c < 1500 && cyc < MAXC - 2; c++) begin
            rp = ($urandom_range(0, 199) == 0);
            st = !rp && ($urandom_range(0, 5) == 0);
            ab = !rp && ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 9))
                0:       k = 0;
                1:       k = $urandom_range(13, 40);
                default: k = $urandom_range(1, 12);
            endcase
            run_cycle(st, k, rp, ab, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
